// File: rtl/bit_seq_tx_pkg.sv
// Shared encodings for the serial pattern transmitter and its shadow 101 detector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bit_seq_tx_pkg;

  // Transmitter states, one-hot
  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    SEND  = 3'b010,
    FLUSH = 3'b100
  } tx_state_t;

  // Shadow 101-detector states, one-hot
  typedef enum logic [3:0] {
    S0 = 4'b0001,
    S1 = 4'b0010,
    S2 = 4'b0100,
    S3 = 4'b1000
  } det_state_t;

  localparam int HITS_W = 8;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [HITS_W-1:0] sat_inc(input logic [HITS_W-1:0] v);
    return (&v) ? v : v + HITS_W'(1);
  endfunction

endpackage

// File: rtl/bit_seq_tx_if.sv
// Handshake/stream bundle between a word source, the transmitter and its observers.
// Latency: n/a (wiring only).
// Backpressure: source may raise Start only while Ready=1; otherwise it is ignored.
interface bit_seq_tx_if #(
  parameter int WIDTH = 8
);
  import bit_seq_tx_pkg::*;

  logic              Start;
  logic [WIDTH-1:0]  Data;
  logic              Ready;
  logic              X;
  logic              X_valid;
  logic              Done;
  logic              Z_exp;
  logic [HITS_W-1:0] Hits;

  modport master (
    output Start, Data,
    input  Ready, X, X_valid, Done, Z_exp, Hits
  );

  modport slave (
    input  Start, Data,
    output Ready, X, X_valid, Done, Z_exp, Hits
  );

endinterface

// File: rtl/seq101_model.sv
// Shadow Moore model of the downstream 101 detector plus a saturating hit counter.
// Latency: Z one cycle after the completing '1' is on the line, same as the real detector.
// Backpressure: none; samples the line every cycle.
module seq101_model
  import bit_seq_tx_pkg::*;
(
  input  logic              Clk,
  input  logic              Clr,
  input  logic              i_x,
  output logic              o_z,
  output logic [HITS_W-1:0] o_hits
);

  det_state_t        r_state;
  det_state_t        w_state_nxt;
  logic [HITS_W-1:0] r_hits;

  // Detector state register
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) r_state <= S0;
    else     r_state <= w_state_nxt;
  end

  // Next-state: overlapping 101 recognition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S0:      if (i_x)  w_state_nxt = S1;
      S1:      if (!i_x) w_state_nxt = S2;
      S2:      w_state_nxt = i_x ? S3 : S0;
      S3:      w_state_nxt = i_x ? S1 : S2;
      default: w_state_nxt = S0;
    endcase
  end

  assign o_z = (r_state == S3);

  // Count every cycle the detector is expected to fire; only Clr clears it
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr)      r_hits <= '0;
    else if (o_z) r_hits <= sat_inc(r_hits);
  end

  assign o_hits = r_hits;

endmodule

// File: rtl/bit_seq_tx.sv
// Parallel-to-serial word sender, MSB first on X, followed by a zero tail for the 101 detector.
// Latency: first bit on X the cycle after Start is accepted; busy WIDTH+FLUSH_BITS cycles per word.
// Backpressure: Ready low while busy; Start during busy is dropped. BIT_SEQ_TX_EXPECT_EN adds Z_exp/Hits.
module bit_seq_tx
  import bit_seq_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int FLUSH_BITS = 2
) (
  input  logic        Clk,
  input  logic        Clr,
  bit_seq_tx_if.slave bus
);

  localparam int CNT_MAX = (WIDTH > FLUSH_BITS) ? WIDTH : FLUSH_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  tx_state_t        r_state;
  tx_state_t        w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_x;

  // State, shift register, bit counter and Done pulse registers
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and datapath: the shifter zero-fills, so it is already empty by FLUSH
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.Start) begin
          w_shreg_nxt = bus.Data;
          w_cnt_nxt   = CNT_W'(WIDTH - 1);
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
        if (r_cnt == '0) begin
          w_cnt_nxt   = CNT_W'(FLUSH_BITS - 1);
          w_state_nxt = FLUSH;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      FLUSH: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_shreg_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // The line is the shifter MSB, so X comes straight from a flop
  assign w_x         = r_shreg[WIDTH-1];
  assign bus.X       = w_x;
  assign bus.X_valid = (r_state == SEND);
  assign bus.Ready   = (r_state == IDLE);
  assign bus.Done    = r_done;

`ifdef BIT_SEQ_TX_EXPECT_EN
  seq101_model u_model (
    .Clk    (Clk),
    .Clr    (Clr),
    .i_x    (w_x),
    .o_z    (bus.Z_exp),
    .o_hits (bus.Hits)
  );
`else
  assign bus.Z_exp = 1'b0;
  assign bus.Hits  = '0;
`endif

endmodule
